// File: rtl/fifo_stream_pkg.sv
// Shared constants and types for the FIFO-to-stream read adapter (fifo_stream_out).
// The optional word counter is enabled with the FIFO_STREAM_CNT_EN macro.
package fifo_stream_pkg;

    localparam int RD_LAT_COMB   = 0;
    localparam int RD_LAT_REG    = 1;
    localparam int CNT_W_DEFAULT = 16;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_stream_skid.sv
// Two-entry in-order buffer between the FIFO read port and the stream output.
// Head is always the oldest word; a simultaneous push and pop keeps occupancy unchanged.
module fifo_stream_skid
    import fifo_stream_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output occ_t         occ,
    output logic [W-1:0] dout
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    occ_t         occ_q, occ_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (flush) begin
            occ_d = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_d = din;
                    end else begin
                        tail_d = din;
                    end
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    head_d = tail_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    // With a single word buffered the new word replaces the departing head.
                    if (occ_q == 2'd1) begin
                        head_d = din;
                    end else begin
                        head_d = tail_q;
                        tail_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign dout = head_q;

endmodule

// File: rtl/fifo_stream_out.sv
// Pops a sync FIFO without underflow and presents the words as a valid/ready stream.
// Define FIFO_STREAM_CNT_EN to enable the accepted-word counter on word_cnt.
module fifo_stream_out
    import fifo_stream_pkg::*;
#(
    parameter int W      = 8,
    parameter int RD_LAT = RD_LAT_COMB,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [W-1:0]     fifo_rd_data,
    output logic             fifo_rd_en,
    input  logic             flush,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] word_cnt
);

    occ_t       occ;
    logic       out_take;
    logic       inflight;
    logic       push;
    logic [2:0] credit_used;

    assign out_valid = (occ != 2'd0);
    assign out_take  = out_valid & out_ready;

    // Words already buffered or in flight consume credit; a word leaving this cycle frees one.
    assign credit_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, out_take};
    assign fifo_rd_en  = !reset && !flush && !fifo_empty && (credit_used < 3'd2);

    generate
        if (RD_LAT == RD_LAT_REG) begin : g_rd_reg
            logic inflight_q, inflight_d;

            always_comb begin
                inflight_d = fifo_rd_en;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    inflight_q <= 1'b0;
                end else begin
                    inflight_q <= inflight_d;
                end
            end

            // A word arriving during flush was popped before the flush and is discarded.
            assign inflight = inflight_q;
            assign push     = inflight_q & !flush;
        end else begin : g_rd_comb
            assign inflight = 1'b0;
            assign push     = fifo_rd_en;
        end
    endgenerate

    fifo_stream_skid #(
        .W(W)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (out_take),
        .flush (flush),
        .din   (fifo_rd_data),
        .occ   (occ),
        .dout  (out_data)
    );

`ifdef FIFO_STREAM_CNT_EN
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    always_comb begin
        word_cnt_d = word_cnt_q;
        if (out_take) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end

    assign word_cnt = word_cnt_q;
`else
    assign word_cnt = '0;
`endif

    a_no_underflow: assert property (@(posedge clk) !(fifo_rd_en && fifo_empty))
        else $error("fifo_stream_out: fifo_rd_en asserted while fifo_empty");
    a_no_overflow: assert property (@(posedge clk) occ <= 2'd2)
        else $error("fifo_stream_out: buffer occupancy above 2");
    a_legal_rd_lat: assert property (@(posedge clk) (RD_LAT == RD_LAT_COMB) || (RD_LAT == RD_LAT_REG))
        else $error("fifo_stream_out: RD_LAT must be 0 or 1");

endmodule
